// File: rtl/duck_round_ctrl.sv
// Duck-hunt round sequencer: phase FSM, per-duck shot/hit bookkeeping, BCD score and hit mask.
// Every output is a flop, so each output's _d value is decoded from the next state.
module duck_round_ctrl #(
  parameter int SHOTS_PER_DUCK   = 3,
  parameter int DUCKS_PER_ROUND  = 10,
  parameter int PASS_HITS        = 6,
  parameter int FLY_FRAMES       = 300,
  parameter int FALL_FRAMES      = 60,
  parameter int ESCAPE_FRAMES    = 90,
  parameter int SHOW_FRAMES      = 90,
  parameter int INTRO_MAX_FRAMES = 600,
  parameter int HIT_HUNDREDS     = 5
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_clk,
  input  logic        Run,
  input  logic        trigger,
  input  logic        hit,
  input  logic        dog_done,
  output logic [3:0]  phase,
  output logic        dog_start,
  output logic        duck_launch,
  output logic [1:0]  shots_left,
  output logic [3:0]  duck_index,
  output logic [9:0]  hits_mask,
  output logic [3:0]  round_num,
  output logic [15:0] score_bcd,
  output logic        game_over
);

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    DOG_INTRO   = 4'd1,
    DUCK_FLY    = 4'd2,
    DUCK_FALL   = 4'd3,
    DUCK_ESCAPE = 4'd4,
    DOG_SHOW    = 4'd5,
    NEXT_DUCK   = 4'd6,
    ROUND_END   = 4'd7,
    GAME_OVER   = 4'd8
  } state_e;

  state_e      state_q, state_d;
  logic        armed_q;
  logic        frame_prev_q, run_prev_q, trig_prev_q;
  logic [9:0]  frame_cnt_q, frame_cnt_d;
  logic [1:0]  shots_left_q, shots_left_d;
  logic [3:0]  duck_index_q, duck_index_d;
  logic [9:0]  hits_mask_q, hits_mask_d;
  logic [3:0]  round_num_q, round_num_d;
  logic [15:0] score_q, score_d;
  logic        dog_start_q, dog_start_d;
  logic        duck_launch_q, duck_launch_d;
  logic        game_over_q, game_over_d;

  logic       frame_tick, run_edge, trig_edge, shot, state_entry;
  logic [9:0] cnt_inc;
  logic [1:0] shots_dec;

  // Edges are suppressed for the first cycle after reset so a Run level held
  // through reset release is not mistaken for a press.
  assign frame_tick = armed_q & frame_clk & ~frame_prev_q;
  assign run_edge   = armed_q & Run & ~run_prev_q;
  assign trig_edge  = armed_q & trigger & ~trig_prev_q;
  assign cnt_inc    = frame_cnt_q + 10'd1;
  assign shot       = trig_edge && (shots_left_q != 2'd0);
  assign shots_dec  = shots_left_q - 2'd1;

  function automatic logic timed_out(input int limit);
    return frame_tick && (cnt_inc == 10'(limit));
  endfunction

  // Adds HIT_HUNDREDS to the hundreds digit; a carry out of 9xxx pins at 9900.
  function automatic logic [15:0] add_hit(input logic [15:0] s);
    logic [4:0]  h;
    logic [15:0] r;
    h = {1'b0, s[11:8]} + 5'(HIT_HUNDREDS);
    if (h < 5'd10)              r = {s[15:12], h[3:0], s[7:0]};
    else if (s[15:12] >= 4'd9)  r = 16'h9900;
    else                        r = {s[15:12] + 4'd1, 4'(h - 5'd10), s[7:0]};
    return r;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= IDLE;
      armed_q       <= 1'b0;
      frame_prev_q  <= 1'b0;
      run_prev_q    <= 1'b0;
      trig_prev_q   <= 1'b0;
      frame_cnt_q   <= '0;
      shots_left_q  <= '0;
      duck_index_q  <= '0;
      hits_mask_q   <= '0;
      round_num_q   <= '0;
      score_q       <= '0;
      dog_start_q   <= 1'b0;
      duck_launch_q <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      armed_q       <= 1'b1;
      frame_prev_q  <= frame_clk;
      run_prev_q    <= Run;
      trig_prev_q   <= trigger;
      frame_cnt_q   <= frame_cnt_d;
      shots_left_q  <= shots_left_d;
      duck_index_q  <= duck_index_d;
      hits_mask_q   <= hits_mask_d;
      round_num_q   <= round_num_d;
      score_q       <= score_d;
      dog_start_q   <= dog_start_d;
      duck_launch_q <= duck_launch_d;
      game_over_q   <= game_over_d;
    end
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:        if (run_edge) state_d = DOG_INTRO;
      DOG_INTRO:   if (dog_done || timed_out(INTRO_MAX_FRAMES)) state_d = DUCK_FLY;
      DUCK_FLY: begin
        // A trigger in the same cycle as the timeout is resolved first.
        if (shot) begin
          if (hit)                                          state_d = DUCK_FALL;
          else if (shots_dec == 2'd0 || timed_out(FLY_FRAMES)) state_d = DUCK_ESCAPE;
        end else if (timed_out(FLY_FRAMES)) begin
          state_d = DUCK_ESCAPE;
        end
      end
      DUCK_FALL:   if (timed_out(FALL_FRAMES))   state_d = DOG_SHOW;
      DUCK_ESCAPE: if (timed_out(ESCAPE_FRAMES)) state_d = DOG_SHOW;
      DOG_SHOW:    if (timed_out(SHOW_FRAMES))   state_d = NEXT_DUCK;
      NEXT_DUCK:   state_d = (duck_index_q < 4'(DUCKS_PER_ROUND - 1)) ? DUCK_FLY : ROUND_END;
      ROUND_END:   state_d = ($countones(hits_mask_q) >= PASS_HITS) ? DOG_INTRO : GAME_OVER;
      GAME_OVER:   if (run_edge) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_comb begin
    state_entry   = (state_d != state_q);
    frame_cnt_d   = state_entry ? 10'd0 : (frame_tick ? cnt_inc : frame_cnt_q);
    dog_start_d   = state_entry && (state_d == DOG_INTRO || state_d == DOG_SHOW);
    duck_launch_d = state_entry && (state_d == DUCK_FLY);
    game_over_d   = (state_d == GAME_OVER);
    shots_left_d  = shots_left_q;
    duck_index_d  = duck_index_q;
    hits_mask_d   = hits_mask_q;
    round_num_d   = round_num_q;
    score_d       = score_q;
    unique case (state_q)
      IDLE: if (state_d == DOG_INTRO) begin
        score_d      = '0;
        hits_mask_d  = '0;
        round_num_d  = 4'd1;
        duck_index_d = '0;
      end
      DOG_INTRO: if (state_d == DUCK_FLY) shots_left_d = 2'(SHOTS_PER_DUCK);
      DUCK_FLY: if (shot) begin
        shots_left_d = shots_dec;
        if (hit) begin
          hits_mask_d = hits_mask_q | (10'd1 << duck_index_q);
          score_d     = add_hit(score_q);
        end
      end
      NEXT_DUCK: if (state_d == DUCK_FLY) begin
        duck_index_d = duck_index_q + 4'd1;
        shots_left_d = 2'(SHOTS_PER_DUCK);
      end
      ROUND_END: if (state_d == DOG_INTRO) begin
        round_num_d  = (round_num_q == 4'd15) ? 4'd15 : round_num_q + 4'd1;
        hits_mask_d  = '0;
        duck_index_d = '0;
      end
      default: ;
    endcase
  end

  assign phase       = state_q;
  assign dog_start   = dog_start_q;
  assign duck_launch = duck_launch_q;
  assign shots_left  = shots_left_q;
  assign duck_index  = duck_index_q;
  assign hits_mask   = hits_mask_q;
  assign round_num   = round_num_q;
  assign score_bcd   = score_q;
  assign game_over   = game_over_q;

endmodule

// File: tb/tb_duck_round_ctrl.sv
// Directed bench for duck_round_ctrl: plays three rounds (pass, pass, fail) with hand-computed expectations.
// Inputs change on the falling edge; outputs are checked on the following falling edge.
module tb_duck_round_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_clk = 1'b0;
  logic        Run = 1'b0;
  logic        trigger = 1'b0;
  logic        hit = 1'b0;
  logic        dog_done = 1'b0;
  logic [3:0]  phase;
  logic        dog_start;
  logic        duck_launch;
  logic [1:0]  shots_left;
  logic [3:0]  duck_index;
  logic [9:0]  hits_mask;
  logic [3:0]  round_num;
  logic [15:0] score_bcd;
  logic        game_over;

  int checks = 0;
  int failures = 0;

  duck_round_ctrl dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_clk   (frame_clk),
    .Run         (Run),
    .trigger     (trigger),
    .hit         (hit),
    .dog_done    (dog_done),
    .phase       (phase),
    .dog_start   (dog_start),
    .duck_launch (duck_launch),
    .shots_left  (shots_left),
    .duck_index  (duck_index),
    .hits_mask   (hits_mask),
    .round_num   (round_num),
    .score_bcd   (score_bcd),
    .game_over   (game_over)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_clk = 1'b1;
      step();
      frame_clk = 1'b0;
      step();
    end
  endtask

  task automatic shoot(input logic h);
    hit = h;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    hit = 1'b0;
    step();
  endtask

  task automatic pulse_dog_done();
    dog_done = 1'b1;
    step();
    dog_done = 1'b0;
  endtask

  task automatic duck_hit();
    shoot(1'b1);
    ticks(60);
    ticks(90);
  endtask

  task automatic duck_miss();
    repeat (3) shoot(1'b0);
    ticks(90);
    ticks(90);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_phase"}, 16'(phase), 16'h0);
    check({tag, "_outs"}, 16'({dog_start, duck_launch, game_over, shots_left}), 16'h0);
    check({tag, "_idx"}, 16'(duck_index), 16'h0);
    check({tag, "_mask"}, 16'(hits_mask), 16'h0);
    check({tag, "_round"}, 16'(round_num), 16'h0);
    check({tag, "_score"}, score_bcd, 16'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with Run already held high: releasing reset must not start a game.
    Run = 1'b1;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    step();
    step();
    check("run_held_no_edge", 16'(phase), 16'h0);
    Run = 1'b0;
    step();
    Run = 1'b1;
    step();
    check("start_phase", 16'(phase), 16'h1);
    check("start_dog_pulse", 16'(dog_start), 16'h1);
    check("start_round", 16'(round_num), 16'h1);
    Run = 1'b0;
    step();
    check("dog_pulse_one_cycle", 16'(dog_start), 16'h0);

    // Round 1, duck 0: hit on the first shot.
    pulse_dog_done();
    check("fly_phase", 16'(phase), 16'h2);
    check("launch_pulse", 16'(duck_launch), 16'h1);
    check("fly_shots", 16'(shots_left), 16'h3);
    check("fly_idx", 16'(duck_index), 16'h0);
    step();
    check("launch_one_cycle", 16'(duck_launch), 16'h0);
    hit = 1'b1;
    trigger = 1'b1;
    step();
    check("hit_shots", 16'(shots_left), 16'h2);
    check("hit_mask", 16'(hits_mask), 16'h001);
    check("hit_score", score_bcd, 16'h0500);
    check("hit_phase", 16'(phase), 16'h3);
    trigger = 1'b0;
    hit = 1'b0;
    step();
    ticks(59);
    check("fall_not_yet", 16'(phase), 16'h3);
    ticks(1);
    check("fall_to_show", 16'(phase), 16'h5);
    ticks(90);
    check("next_idx", 16'(duck_index), 16'h1);
    check("next_phase", 16'(phase), 16'h2);
    check("next_shots", 16'(shots_left), 16'h3);

    // Duck 1: three misses, then a fourth trigger that must be ignored.
    repeat (3) shoot(1'b0);
    check("miss_shots", 16'(shots_left), 16'h0);
    check("miss_phase", 16'(phase), 16'h4);
    check("miss_score", score_bcd, 16'h0500);
    shoot(1'b1);
    check("extra_trig_shots", 16'(shots_left), 16'h0);
    check("extra_trig_mask", 16'(hits_mask), 16'h001);
    ticks(90);
    check("escape_to_show", 16'(phase), 16'h5);
    ticks(90);

    // Duck 2: fly timeout.
    ticks(299);
    check("fly_not_timed_out", 16'(phase), 16'h2);
    ticks(1);
    check("fly_timeout", 16'(phase), 16'h4);
    ticks(180);

    // Duck 3: hitting trigger coincides with the fly timeout tick.
    check("duck3_idx", 16'(duck_index), 16'h3);
    ticks(299);
    frame_clk = 1'b1;
    trigger = 1'b1;
    hit = 1'b1;
    step();
    check("coincide_phase", 16'(phase), 16'h3);
    check("coincide_mask", 16'(hits_mask), 16'h009);
    check("coincide_score", score_bcd, 16'h1000);
    frame_clk = 1'b0;
    trigger = 1'b0;
    hit = 1'b0;
    step();
    ticks(150);

    // Duck 4: hit; dog_done during DOG_SHOW is ignored.
    shoot(1'b1);
    ticks(60);
    pulse_dog_done();
    check("show_ignores_dog_done", 16'(phase), 16'h5);
    ticks(90);
    repeat (3) duck_hit();
    repeat (2) duck_miss();
    check("r1_round_end", 16'(phase), 16'h7);
    check("r1_mask", 16'(hits_mask), 16'h0F9);
    step();
    check("r1_pass_phase", 16'(phase), 16'h1);
    check("r1_pass_round", 16'(round_num), 16'h2);
    check("r1_pass_mask", 16'(hits_mask), 16'h000);
    check("r1_pass_idx", 16'(duck_index), 16'h0);
    check("r1_pass_score", score_bcd, 16'h3000);
    check("r1_pass_dog_start", 16'(dog_start), 16'h1);

    // Round 2: all ten ducks hit.
    pulse_dog_done();
    repeat (10) duck_hit();
    check("r2_mask", 16'(hits_mask), 16'h3FF);
    check("r2_score", score_bcd, 16'h8000);
    step();
    check("r2_pass_round", 16'(round_num), 16'h3);

    // Round 3: score reaches and holds 9900; only 5 hits -> game over.
    pulse_dog_done();
    repeat (3) duck_hit();
    check("r3_score_9500", score_bcd, 16'h9500);
    shoot(1'b1);
    check("r3_score_sat", score_bcd, 16'h9900);
    ticks(150);
    shoot(1'b1);
    check("r3_score_hold", score_bcd, 16'h9900);
    ticks(150);
    repeat (5) duck_miss();
    check("r3_mask", 16'(hits_mask), 16'h01F);
    step();
    check("over_phase", 16'(phase), 16'h8);
    check("over_flag", 16'(game_over), 16'h1);
    check("over_round", 16'(round_num), 16'h3);
    shoot(1'b1);
    check("over_ignores_trigger", score_bcd, 16'h9900);
    Run = 1'b1;
    step();
    check("over_to_idle", 16'(phase), 16'h0);
    check("idle_flag_low", 16'(game_over), 16'h0);
    Run = 1'b0;
    step();

    // New game clears score; reset asserted mid-fall clears everything at once.
    Run = 1'b1;
    step();
    Run = 1'b0;
    check("restart_phase", 16'(phase), 16'h1);
    check("restart_score", score_bcd, 16'h0);
    pulse_dog_done();
    shoot(1'b1);
    ticks(5);
    check("pre_reset_phase", 16'(phase), 16'h3);
    #2;
    Reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge Clk);
    Reset_n = 1'b1;
    step();
    check("post_reset_phase", 16'(phase), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
